// File: rtl/kbd_fifo_writer.sv
// PS/2 keyboard receiver and scan-code-to-ASCII decoder feeding the 8-entry keyboard FIFO.
// Optional caps-lock handling is compiled in with `define CAPS_LOCK_EN.
module kbd_fifo_writer #(
  parameter int TIMEOUT_CYC = 50000,
  parameter int SYNC_STAGES = 3
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic [2:0] r_ptr,
  output logic       we_fifo,
  output logic [7:0] datain_fifo,
  output logic [2:0] count,
  output logic       overflow,
  output logic       shift_st
);

  typedef enum logic [2:0] {IDLE, RECV, CHECK, DECODE, WRITE} state_t;

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] kclk_q, kdat_q;
  logic                   kclk_prev_q;
  logic [3:0]             bitcnt_q;
  logic [9:0]             frame_q;
  logic [TW-1:0]          tmo_q;
  logic                   brk_q, ext_q, shift_q;
  logic [7:0]             ascii_q, datain_q;
  logic [2:0]             w_ptr_q;
  logic                   we_q, ovf_q;
`ifdef CAPS_LOCK_EN
  logic                   caps_q;
`endif

  logic       fall_d, bit_d, upper_d, mapped_d;
  logic [7:0] code_d, ascii_d;

  function automatic logic [8:0] map_code(input logic [7:0] code, input logic ext,
                                          input logic upper, input logic shift);
    logic [7:0] a;
    logic       m, letter;
    a = 8'h00; m = 1'b1; letter = 1'b0;
    if (ext) begin
      case (code)
        8'h4A:   a = 8'h2F;
        8'h5A:   a = 8'h0A;
        default: m = 1'b0;
      endcase
    end else begin
      case (code)
        8'h1C: begin a = "a"; letter = 1'b1; end  8'h32: begin a = "b"; letter = 1'b1; end
        8'h21: begin a = "c"; letter = 1'b1; end  8'h23: begin a = "d"; letter = 1'b1; end
        8'h24: begin a = "e"; letter = 1'b1; end  8'h2B: begin a = "f"; letter = 1'b1; end
        8'h34: begin a = "g"; letter = 1'b1; end  8'h33: begin a = "h"; letter = 1'b1; end
        8'h43: begin a = "i"; letter = 1'b1; end  8'h3B: begin a = "j"; letter = 1'b1; end
        8'h42: begin a = "k"; letter = 1'b1; end  8'h4B: begin a = "l"; letter = 1'b1; end
        8'h3A: begin a = "m"; letter = 1'b1; end  8'h31: begin a = "n"; letter = 1'b1; end
        8'h44: begin a = "o"; letter = 1'b1; end  8'h4D: begin a = "p"; letter = 1'b1; end
        8'h15: begin a = "q"; letter = 1'b1; end  8'h2D: begin a = "r"; letter = 1'b1; end
        8'h1B: begin a = "s"; letter = 1'b1; end  8'h2C: begin a = "t"; letter = 1'b1; end
        8'h3C: begin a = "u"; letter = 1'b1; end  8'h2A: begin a = "v"; letter = 1'b1; end
        8'h1D: begin a = "w"; letter = 1'b1; end  8'h22: begin a = "x"; letter = 1'b1; end
        8'h35: begin a = "y"; letter = 1'b1; end  8'h1A: begin a = "z"; letter = 1'b1; end
        8'h45: a = shift ? ")" : "0";
        8'h16: a = "1";  8'h1E: a = "2";  8'h26: a = "3";  8'h25: a = "4";
        8'h2E: a = "5";  8'h36: a = "6";  8'h3D: a = "7";
        8'h3E: a = shift ? "*" : "8";
        8'h46: a = shift ? "(" : "9";
        8'h55: a = shift ? "+" : "=";
        8'h4E: a = "-";  8'h4A: a = "/";  8'h49: a = ".";
        8'h29: a = 8'h20;  8'h5A: a = 8'h0A;  8'h66: a = 8'h08;
        8'h79: a = "+";  8'h7B: a = "-";  8'h7C: a = "*";  8'h71: a = ".";
        8'h70: a = "0";  8'h69: a = "1";  8'h72: a = "2";  8'h7A: a = "3";
        8'h6B: a = "4";  8'h73: a = "5";  8'h74: a = "6";  8'h6C: a = "7";
        8'h75: a = "8";  8'h7D: a = "9";
        default: m = 1'b0;
      endcase
      if (letter && upper) a = a - 8'h20;
    end
    return {m, a};
  endfunction

  always_comb begin
    fall_d = kclk_prev_q & ~kclk_q[SYNC_STAGES-1];
    bit_d  = kdat_q[SYNC_STAGES-1];
    code_d = frame_q[7:0];
`ifdef CAPS_LOCK_EN
    upper_d = shift_q ^ caps_q;
`else
    upper_d = shift_q;
`endif
    {mapped_d, ascii_d} = map_code(code_d, ext_q, upper_d, shift_q);
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q     <= IDLE;
      kclk_q      <= '1;
      kdat_q      <= '1;
      kclk_prev_q <= 1'b1;
      bitcnt_q    <= '0;
      frame_q     <= '0;
      tmo_q       <= '0;
      brk_q       <= 1'b0;
      ext_q       <= 1'b0;
      shift_q     <= 1'b0;
      ascii_q     <= '0;
      datain_q    <= '0;
      w_ptr_q     <= '0;
      we_q        <= 1'b0;
      ovf_q       <= 1'b0;
`ifdef CAPS_LOCK_EN
      caps_q      <= 1'b0;
`endif
    end else begin
      kclk_q      <= {kclk_q[SYNC_STAGES-2:0], ps2_clk};
      kdat_q      <= {kdat_q[SYNC_STAGES-2:0], ps2_data};
      kclk_prev_q <= kclk_q[SYNC_STAGES-1];
      we_q        <= 1'b0;
      case (state_q)
        IDLE: if (fall_d && !bit_d) begin
          state_q  <= RECV;
          bitcnt_q <= 4'd1;
          tmo_q    <= '0;
        end
        RECV: if (fall_d) begin
          frame_q  <= {bit_d, frame_q[9:1]};
          bitcnt_q <= bitcnt_q + 4'd1;
          tmo_q    <= '0;
          if (bitcnt_q == 4'd10) state_q <= CHECK;
        end else if (tmo_q == TW'(TIMEOUT_CYC)) begin
          state_q <= IDLE;
        end else begin
          tmo_q <= tmo_q + 1'b1;
        end
        CHECK: state_q <= (^frame_q[8:0] && frame_q[9]) ? DECODE : IDLE;
        DECODE: begin
          state_q <= IDLE;
          if (code_d == 8'hF0) brk_q <= 1'b1;
          else if (code_d == 8'hE0) ext_q <= 1'b1;
          else begin
            brk_q <= 1'b0;
            ext_q <= 1'b0;
            if (code_d == 8'h12 || code_d == 8'h59) shift_q <= ~brk_q;
`ifdef CAPS_LOCK_EN
            else if (code_d == 8'h58) begin
              if (!brk_q) caps_q <= ~caps_q;
            end
`endif
            else if (!brk_q && mapped_d) begin
              ascii_q <= ascii_d;
              state_q <= WRITE;
            end
          end
        end
        WRITE: begin
          state_q <= IDLE;
          // One slot stays empty so a full FIFO is distinguishable from an empty one.
          if (w_ptr_q + 3'd1 != r_ptr) begin
            we_q     <= 1'b1;
            datain_q <= ascii_q;
            w_ptr_q  <= w_ptr_q + 3'd1;
          end else begin
            ovf_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    we_fifo     = we_q;
    datain_fifo = datain_q;
    count       = w_ptr_q;
    overflow    = ovf_q;
    shift_st    = shift_q;
  end

endmodule

// File: tb/tb_kbd_fifo_writer.sv
// Scoreboard bench for kbd_fifo_writer: frames are driven on the PS/2 pins, expected writes are
// queued at the stop-bit edge and checked by an independent monitor.
module tb_kbd_fifo_writer;
  localparam int TMO  = 200;
  localparam int SS   = 3;
  localparam int HALF = 8;
  // synchroniser depth + edge detect + three FSM cycles to the write strobe
  localparam int EXP_LAT = SS + 1 + 3;

  logic       clk = 1'b0, clrn, ps2_clk, ps2_data;
  logic [2:0] r_ptr;
  logic       we_fifo, overflow, shift_st;
  logic [7:0] datain_fifo;
  logic [2:0] count;

  kbd_fifo_writer #(.TIMEOUT_CYC(TMO), .SYNC_STAGES(SS)) dut (
    .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .r_ptr(r_ptr),
    .we_fifo(we_fifo), .datain_fifo(datain_fifo), .count(count),
    .overflow(overflow), .shift_st(shift_st)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] data; logic [2:0] cnt; int t; } exp_t;
  exp_t sbq[$];
  int cyc = 0, n_cmp = 0, n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (we_fifo) begin
      if (sbq.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_write: got data=%0h count=%0d expected no write", datain_fifo, count);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("wr_data", int'(datain_fifo), int'(e.data));
        check("wr_count", int'(count), int'(e.cnt));
        check("wr_latency", cyc - e.t, EXP_LAT);
      end
    end
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_raw(input logic [10:0] bits, input int nbits, input bit expw,
                          input logic [7:0] d, input logic [2:0] c);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      wait_neg(HALF);
      ps2_clk = 1'b0;
      if (i == 10 && expw) sbq.push_back('{data: d, cnt: c, t: cyc});
      wait_neg(HALF);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    wait_neg(12);
  endtask

  function automatic logic [10:0] frame(input logic [7:0] code);
    return {1'b1, ~^code, code, 1'b0};
  endfunction

  task automatic key(input logic [7:0] code);
    send_raw(frame(code), 11, 1'b0, 8'h00, 3'd0);
  endtask

  task automatic keyw(input logic [7:0] code, input logic [7:0] d, input logic [2:0] c);
    send_raw(frame(code), 11, 1'b1, d, c);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"}, int'(we_fifo), 0);
    check({tag, "_data"}, int'(datain_fifo), 0);
    check({tag, "_count"}, int'(count), 0);
    check({tag, "_overflow"}, int'(overflow), 0);
    check({tag, "_shift"}, int'(shift_st), 0);
  endtask

  task automatic pulse_reset();
    clrn = 1'b0;
    wait_neg(3);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [10:0] bad;
    clrn = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; r_ptr = 3'd0;
    wait_neg(5);
    check_reset_outputs("reset");
    clrn = 1'b1;
    wait_neg(5);

    keyw(8'h1C, 8'h61, 3'd1);

    key(8'h12);
    check("shift_make", int'(shift_st), 1);
    keyw(8'h1C, 8'h41, 3'd2);
    key(8'hF0); key(8'h1C);
    key(8'hF0); key(8'h12);
    check("shift_break", int'(shift_st), 0);

    bad = frame(8'h1C); bad[9] = ~bad[9];
    send_raw(bad, 11, 1'b0, 8'h00, 3'd0);
    bad = frame(8'h1C); bad[10] = 1'b0;
    send_raw(bad, 11, 1'b0, 8'h00, 3'd0);
    keyw(8'h45, 8'h30, 3'd3);

    send_raw(frame(8'h1C), 5, 1'b0, 8'h00, 3'd0);
    wait_neg(TMO + 50);
    keyw(8'h29, 8'h20, 3'd4);

    pulse_reset();
    clrn = 1'b1;
    wait_neg(5);
    for (int i = 1; i <= 7; i++) keyw(8'h16, 8'h31, 3'(i));
    check("overflow_before_full", int'(overflow), 0);
    key(8'h16);
    check("overflow_set", int'(overflow), 1);
    r_ptr = 3'd3;
    keyw(8'h16, 8'h31, 3'd0);
    check("overflow_sticky", int'(overflow), 1);

    send_raw(frame(8'h1C), 5, 1'b0, 8'h00, 3'd0);
    pulse_reset();
    check_reset_outputs("midframe_reset");
    clrn = 1'b1;
    wait_neg(5);
    keyw(8'h1C, 8'h61, 3'd1);

    r_ptr = 3'd1;
    keyw(8'h55, 8'h3D, 3'd2);
    key(8'hE0); keyw(8'h4A, 8'h2F, 3'd3);
    key(8'hE0); key(8'h1C);
    key(8'h12); keyw(8'h3E, 8'h2A, 3'd4);
    key(8'hF0); key(8'h12);
    keyw(8'h7C, 8'h2A, 3'd5);
`ifdef CAPS_LOCK_EN
    key(8'h58); keyw(8'h1C, 8'h41, 3'd6);
    key(8'h12); keyw(8'h1C, 8'h61, 3'd7);
    key(8'hF0); key(8'h12);
`else
    key(8'h58); keyw(8'h1C, 8'h61, 3'd6);
`endif

    wait_neg(20);
    check("scoreboard_drained", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
